// File: rtl/cmp_pipe.sv
// cmp_pipe: pipelined ten-function compare unit, valid/ready in and out, STAGES=1|2 deep.
// Optional build macro CMP_PIPE_STATS_EN adds saturating transfer/true-result counters.
module cmp_pipe #(
   parameter int W      = 32,
   parameter int STAGES = 1,
   parameter int TAGW   = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      in_fcn,
   input  logic [W-1:0]    in_a,
   input  logic [W-1:0]    in_b,
   input  logic [TAGW-1:0] in_tag,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            out_res,
   output logic            out_err,
   output logic [TAGW-1:0] out_tag
`ifdef CMP_PIPE_STATS_EN
   ,
   output logic [15:0]     stat_ops,
   output logic [15:0]     stat_true
`endif
);

   function automatic logic sel_res(input logic [3:0] fcn, input logic eq,
                                    input logic ltu, input logic lts);
      logic r;
      case (fcn)
         4'd0:    r = eq;
         4'd1:    r = !eq;
         4'd2:    r = lts;
         4'd3:    r = !lts;
         4'd4:    r = lts | eq;
         4'd5:    r = !(lts | eq);
         4'd6:    r = ltu;
         4'd7:    r = !ltu;
         4'd8:    r = ltu | eq;
         4'd9:    r = !(ltu | eq);
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   logic            v_out;
   logic            res_q;
   logic            err_q;
   logic [TAGW-1:0] tag_q;
   logic            out_load;

   assign out_load  = !v_out | out_ready;
   // Data regs are not reset; gating with valid keeps idle outputs at zero.
   assign out_valid = v_out;
   assign out_res   = v_out & res_q;
   assign out_err   = v_out & err_q;
   assign out_tag   = v_out ? tag_q : '0;

   if (W < 2 || W > 128 || TAGW < 1 || TAGW > 16) begin : g_bad_width
      $error("cmp_pipe: W or TAGW out of range");
   end

   if (STAGES == 1) begin : g_s1
      assign in_ready = out_load;

      always_ff @(posedge clk) begin
         if (rst)
            v_out <= 1'b0;
         else if (out_load)
            v_out <= in_valid;
      end

      always_ff @(posedge clk) begin
         if (out_load && in_valid) begin
            res_q <= sel_res(in_fcn, in_a == in_b, in_a < in_b, $signed(in_a) < $signed(in_b));
            err_q <= in_fcn >= 4'd10;
            tag_q <= in_tag;
         end
      end
   end else if (STAGES == 2) begin : g_s2
      localparam int H = W / 2;

      if (W % 2 != 0) begin : g_bad_odd
         $error("cmp_pipe: W must be even when STAGES=2");
      end

      logic            v1;
      logic            ld1;
      logic            eq_lo, ltu_lo, eq_hi, ltu_hi, lts_hi;
      logic [3:0]      fcn1;
      logic [TAGW-1:0] tag1;
      logic            eq, ltu, lts;

      assign ld1      = !v1 | out_load;
      assign in_ready = ld1;

      always_ff @(posedge clk) begin
         if (rst) begin
            v1    <= 1'b0;
            v_out <= 1'b0;
         end else begin
            if (ld1)
               v1 <= in_valid;
            if (out_load)
               v_out <= v1;
         end
      end

      // Split the compare at the half boundary so each stage sees a W/2 carry chain.
      always_ff @(posedge clk) begin
         if (ld1 && in_valid) begin
            eq_lo  <= in_a[H-1:0] == in_b[H-1:0];
            ltu_lo <= in_a[H-1:0] <  in_b[H-1:0];
            eq_hi  <= in_a[W-1:H] == in_b[W-1:H];
            ltu_hi <= in_a[W-1:H] <  in_b[W-1:H];
            lts_hi <= $signed(in_a[W-1:H]) < $signed(in_b[W-1:H]);
            fcn1   <= in_fcn;
            tag1   <= in_tag;
         end
      end

      assign eq  = eq_hi & eq_lo;
      assign ltu = ltu_hi | (eq_hi & ltu_lo);
      assign lts = lts_hi | (eq_hi & ltu_lo);

      always_ff @(posedge clk) begin
         if (out_load && v1) begin
            res_q <= sel_res(fcn1, eq, ltu, lts);
            err_q <= fcn1 >= 4'd10;
            tag_q <= tag1;
         end
      end
   end else begin : g_bad_stages
      $error("cmp_pipe: STAGES must be 1 or 2");
   end

`ifdef CMP_PIPE_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_ops  <= 16'd0;
         stat_true <= 16'd0;
      end else if (out_valid && out_ready) begin
         if (stat_ops != 16'hFFFF)
            stat_ops <= stat_ops + 16'd1;
         if (out_res && stat_true != 16'hFFFF)
            stat_true <= stat_true + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cmp_pipe.sv
// Scoreboard bench for cmp_pipe: a 1-stage and a 2-stage instance, directed vectors.
module tb_cmp_pipe;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        iv1, or1, iv2, or2;
   logic [3:0]  f1, f2, t1, t2;
   logic [31:0] a1, b1, a2, b2;
   logic        ir1, ov1, res1, err1, ir2, ov2, res2, err2;
   logic [3:0]  ot1, ot2;
`ifdef CMP_PIPE_STATS_EN
   logic [15:0] so1, st1, so2, st2;
`endif

   cmp_pipe #(.W(32), .STAGES(1), .TAGW(4)) u_d1 (
      .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_fcn(f1),
      .in_a(a1), .in_b(b1), .in_tag(t1), .out_valid(ov1), .out_ready(or1),
      .out_res(res1), .out_err(err1), .out_tag(ot1)
`ifdef CMP_PIPE_STATS_EN
      , .stat_ops(so1), .stat_true(st1)
`endif
   );

   cmp_pipe #(.W(32), .STAGES(2), .TAGW(4)) u_d2 (
      .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .in_fcn(f2),
      .in_a(a2), .in_b(b2), .in_tag(t2), .out_valid(ov2), .out_ready(or2),
      .out_res(res2), .out_err(err2), .out_tag(ot2)
`ifdef CMP_PIPE_STATS_EN
      , .stat_ops(so2), .stat_true(st2)
`endif
   );

   typedef struct {
      logic       res;
      logic       err;
      logic [3:0] tag;
   } exp_t;

   typedef struct {
      logic [3:0]  fcn;
      logic [31:0] a;
      logic [31:0] b;
      logic        res;
      logic        err;
   } vec_t;

   exp_t q1[$];
   exp_t q2[$];
   exp_t e1, e2;
   int   n_chk  = 0;
   int   n_pass = 0;
   bit   mon_off1 = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Monitors: pop and compare whenever a DUT completes an output transfer.
   always @(negedge clk) begin
      if (!rst && ov1 && or1 && !mon_off1) begin
         if (q1.size() == 0) chk("d1 unexpected result", 32'd1, 32'd0);
         else begin
            e1 = q1.pop_front();
            chk("d1 res", {31'd0, res1}, {31'd0, e1.res});
            chk("d1 err", {31'd0, err1}, {31'd0, e1.err});
            chk("d1 tag", {28'd0, ot1}, {28'd0, e1.tag});
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && ov2 && or2) begin
         if (q2.size() == 0) chk("d2 unexpected result", 32'd1, 32'd0);
         else begin
            e2 = q2.pop_front();
            chk("d2 res", {31'd0, res2}, {31'd0, e2.res});
            chk("d2 err", {31'd0, err2}, {31'd0, e2.err});
            chk("d2 tag", {28'd0, ot2}, {28'd0, e2.tag});
         end
      end
   end

   // All tasks are entered and left at posedge+1.
   task automatic send(input int d, input logic [3:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] t, input logic r,
                       input logic e);
      exp_t x;
      int   n;
      logic rdy;
      x.res = r; x.err = e; x.tag = t;
      if (d == 1) begin iv1 = 1'b1; f1 = f; a1 = a; b1 = b; t1 = t; end
      else        begin iv2 = 1'b1; f2 = f; a2 = a; b2 = b; t2 = t; end
      n = 0;
      do begin
         @(negedge clk);
         n++;
         rdy = (d == 1) ? ir1 : ir2;
      end while (!rdy && n < 50);
      if (!rdy) chk("send timeout", 32'd0, 32'd1);
      else if (d == 1) q1.push_back(x);
      else q2.push_back(x);
      @(posedge clk); #1;
      if (d == 1) iv1 = 1'b0; else iv2 = 1'b0;
   endtask

   task automatic wait_valid(input int d, input int exp_cyc, input string name);
      int   n;
      logic v;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         v = (d == 1) ? ov1 : ov2;
      end while (!v && n < 10);
      chk(name, n, exp_cyc);
      @(posedge clk); #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q1.size() != 0 || q2.size() != 0) && n < 100) begin
         @(negedge clk); #1;
         n++;
      end
      chk("drain q1 empty", q1.size(), 32'd0);
      chk("drain q2 empty", q2.size(), 32'd0);
      @(posedge clk); #1;
   endtask

   vec_t        vecs[$];
   logic [9:0]  code_exp;
   vec_t        v;
   int          n;

   initial begin
      iv1 = 0; iv2 = 0; or1 = 1; or2 = 1;
      f1 = 0; f2 = 0; a1 = 0; a2 = 0; b1 = 0; b2 = 0; t1 = 0; t2 = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("d1 reset outputs", {25'd0, ov1, res1, err1, ot1}, 32'd0);
      chk("d2 reset outputs", {25'd0, ov2, res2, err2, ot2}, 32'd0);
      chk("d1 reset in_ready", {31'd0, ir1}, 32'd1);
      chk("d2 reset in_ready", {31'd0, ir2}, 32'd1);
      @(posedge clk); #1;

      // Single-stage: signed vs unsigned view of all-ones against zero.
      send(1, 4'd2, 32'hFFFF_FFFF, 32'd0, 4'd3, 1'b1, 1'b0);
      wait_valid(1, 1, "d1 latency");
      send(1, 4'd6, 32'hFFFF_FFFF, 32'd0, 4'd4, 1'b0, 1'b0);
      drain();

      // Two-stage: latency, then back-to-back issue.
      send(2, 4'd0, 32'h1234_5678, 32'h1234_5678, 4'd5, 1'b1, 1'b0);
      wait_valid(2, 2, "d2 latency");
      send(2, 4'd0, 32'h1234_5678, 32'h1234_5678, 4'd5, 1'b1, 1'b0);
      send(2, 4'd6, 32'h0001_0000, 32'h0000_FFFF, 4'd6, 1'b0, 1'b0);
      drain();

      // -128 vs 127: EQ0 NE1 LT1 GE0 LE1 GT0 LTU0 GEU1 LEU0 GTU1
      code_exp = 10'b10_1001_0110;
      for (int i = 0; i < 10; i++) begin
         v.fcn = i[3:0]; v.a = 32'hFFFF_FF80; v.b = 32'h0000_007F;
         v.res = code_exp[i]; v.err = 1'b0;
         vecs.push_back(v);
      end
      vecs.push_back('{4'd10, 32'd5, 32'd5, 1'b0, 1'b1});
      vecs.push_back('{4'd12, 32'd5, 32'd5, 1'b0, 1'b1});
      vecs.push_back('{4'd15, 32'd5, 32'd5, 1'b0, 1'b1});
      vecs.push_back('{4'd2, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0});
      vecs.push_back('{4'd6, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0});
      vecs.push_back('{4'd2, 32'h1234_0001, 32'h1234_0002, 1'b1, 1'b0});
      vecs.push_back('{4'd9, 32'h1234_0001, 32'h1234_0002, 1'b0, 1'b0});
      vecs.push_back('{4'd5, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0});
      vecs.push_back('{4'd3, 32'h0000_ABCD, 32'h0000_ABCD, 1'b1, 1'b0});
      vecs.push_back('{4'd8, 32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0});
      for (int i = 0; i < vecs.size(); i++) begin
         send(1, vecs[i].fcn, vecs[i].a, vecs[i].b, i[3:0], vecs[i].res, vecs[i].err);
         send(2, vecs[i].fcn, vecs[i].a, vecs[i].b, i[3:0], vecs[i].res, vecs[i].err);
      end
      drain();

      // Backpressure: two accepted, third blocked, outputs held.
      or2 = 1'b0;
      send(2, 4'd0, 32'd5, 32'd5, 4'd1, 1'b1, 1'b0);
      send(2, 4'd1, 32'd5, 32'd5, 4'd2, 1'b0, 1'b0);
      iv2 = 1'b1; f2 = 4'd7; a2 = 32'd5; b2 = 32'd3; t2 = 4'd3;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp in_ready low", {31'd0, ir2}, 32'd0);
         chk("bp outputs held", {25'd0, ov2, res2, err2, ot2}, {25'd0, 1'b1, 1'b1, 1'b0, 4'd1});
      end
      @(posedge clk); #1;
      or2 = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!ir2 && n < 10);
      chk("bp drain+accept same cycle", n, 32'd1);
      q2.push_back('{1'b1, 1'b0, 4'd3});
      @(posedge clk); #1;
      iv2 = 1'b0;
      drain();

      // Reset with a full pipe: nothing in flight may ever emerge.
      or2 = 1'b0;
      send(2, 4'd0, 32'd1, 32'd1, 4'd7, 1'b1, 1'b0);
      send(2, 4'd0, 32'd1, 32'd1, 4'd8, 1'b1, 1'b0);
      rst = 1'b1;
      q2.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst outputs cleared", {25'd0, ov2, res2, err2, ot2}, 32'd0);
      chk("rst in_ready", {31'd0, ir2}, 32'd1);
      @(posedge clk); #1;
      or2 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("no stale result", {31'd0, ov2}, 32'd0);
      end
      @(posedge clk); #1;
      send(2, 4'd4, 32'd3, 32'd3, 4'd9, 1'b1, 1'b0);
      drain();

`ifdef CMP_PIPE_STATS_EN
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      send(1, 4'd0, 32'd7, 32'd7, 4'd1, 1'b1, 1'b0);
      send(1, 4'd1, 32'd7, 32'd7, 4'd2, 1'b0, 1'b0);
      send(1, 4'd6, 32'd1, 32'd2, 4'd3, 1'b1, 1'b0);
      send(1, 4'd9, 32'd3, 32'd2, 4'd4, 1'b1, 1'b0);
      drain();
      @(negedge clk);
      chk("stat_ops", {16'd0, so1}, 32'd4);
      chk("stat_true", {16'd0, st1}, 32'd3);
      chk("d2 stat_ops after rst", {16'd0, so2}, 32'd0);
      @(posedge clk); #1;
      mon_off1 = 1'b1;
      iv1 = 1'b1; f1 = 4'd0; a1 = 32'd0; b1 = 32'd0; t1 = 4'd0;
      repeat (65540) @(posedge clk);
      #1 iv1 = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("stat_ops saturated", {16'd0, so1}, 32'h0000_FFFF);
      chk("stat_true saturated", {16'd0, st1}, 32'h0000_FFFF);
      mon_off1 = 1'b0;
      @(posedge clk); #1;
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete, %0d/%0d", n_pass, n_chk);
      $fatal(1);
   end

endmodule
